// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one Avalon-style SDRAM controller port between
// the northbridge memory path (port 0) and a secondary master (port 1).
// One master is granted at a time. The grant is held until that master's
// command is accepted. Read returns are steered back to the issuing port
// through a small FIFO of outstanding-read tags.
module sdram_port_arbiter #(
  parameter int ADDR_W       = 22,
  parameter int DATA_W       = 16,
  parameter int BE_W         = 2,
  parameter int MAX_PEND     = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  // port 0: northbridge
  input  logic [ADDR_W-1:0]           m0_addr,
  input  logic [BE_W-1:0]             m0_be_n,
  input  logic [DATA_W-1:0]           m0_data,
  input  logic                        m0_rd_n,
  input  logic                        m0_wr_n,
  output logic                        m0_waitrequest,
  output logic [DATA_W-1:0]           m0_rdata,
  output logic                        m0_valid,
  // port 1: debug loader / DMA
  input  logic [ADDR_W-1:0]           m1_addr,
  input  logic [BE_W-1:0]             m1_be_n,
  input  logic [DATA_W-1:0]           m1_data,
  input  logic                        m1_rd_n,
  input  logic                        m1_wr_n,
  output logic                        m1_waitrequest,
  output logic [DATA_W-1:0]           m1_rdata,
  output logic                        m1_valid,
  // SDRAM controller slave port
  output logic [ADDR_W-1:0]           az_addr,
  output logic [BE_W-1:0]             az_be_n,
  output logic [DATA_W-1:0]           az_data,
  output logic                        az_rd_n,
  output logic                        az_wr_n,
  input  logic [DATA_W-1:0]           za_data,
  input  logic                        za_valid,
  input  logic                        za_waitrequest,
  // status
  output logic                        rd_err,
  output logic [$clog2(MAX_PEND):0]   pend_cnt
);

  localparam int PTR_W = $clog2(MAX_PEND);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_G0   = 2'd1,
    ST_G1   = 2'd2
  } state_e;

  state_e           state_q, state_d, sel_state;
  logic             req0, req1;
  logic             gnt_rd, gnt_wr, gnt_req, gnt_id;
  logic             accept, acc0, acc1;
  logic             fifo_full, fifo_empty, push, pop, head_id;
  logic [SC_W-1:0]  starve_q, starve_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_err_q;
  logic             tag_mem [MAX_PEND];

  assign req0 = ~m0_rd_n | ~m0_wr_n;
  assign req1 = ~m1_rd_n | ~m1_wr_n;

  // Route the granted master onto the controller port; idle drives a quiet bus.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    gnt_wr  = 1'b0;
    gnt_rd  = 1'b0;
    gnt_id  = 1'b0;
    az_addr = '0;
    az_data = '0;
    az_be_n = '1;
    case (state_q)
      ST_G0: begin
        gnt_wr  = ~m0_wr_n;
        gnt_rd  = ~m0_rd_n & m0_wr_n;   // write wins when both are low
        az_addr = m0_addr;
        az_data = m0_data;
        az_be_n = m0_be_n;
      end
      ST_G1: begin
        gnt_id  = 1'b1;
        gnt_wr  = ~m1_wr_n;
        gnt_rd  = ~m1_rd_n & m1_wr_n;
        az_addr = m1_addr;
        az_data = m1_data;
        az_be_n = m1_be_n;
      end
      default: ;
    endcase
  end

  // A read is held off the bus while every tag slot is in use.
  assign gnt_req        = gnt_wr | gnt_rd;
  assign az_wr_n        = ~gnt_wr;
  assign az_rd_n        = ~(gnt_rd & ~fifo_full);
  assign accept         = gnt_req & ~za_waitrequest & ~(gnt_rd & fifo_full);
  assign acc0           = accept & (state_q == ST_G0);
  assign acc1           = accept & (state_q == ST_G1);
  assign m0_waitrequest = ~acc0;
  assign m1_waitrequest = ~acc1;

  // Count port-0 wins while port 1 is waiting; a port-1 win clears it.
  always_comb begin
    starve_d = starve_q;
    if (acc1) begin
      starve_d = '0;
    end else if (acc0 && req1 && (starve_q != SC_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + SC_W'(1);
    end
  end

  // Pick the next owner. The count including this cycle's accept is used,
  // so port 1 wins right after the STARVE_LIMIT-th consecutive port-0 accept.
  always_comb begin
    sel_state = ST_IDLE;
    if (req1 && ((starve_d == SC_W'(STARVE_LIMIT)) || !req0)) begin
      sel_state = ST_G1;
    end else if (req0) begin
      sel_state = ST_G0;
    end
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = sel_state;
      ST_G0, ST_G1: begin
        if (!gnt_req) begin
          state_d = ST_IDLE;            // master withdrew while granted
        end else if (accept) begin
          state_d = sel_state;          // re-arbitrate on the accept edge
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Grant state, starvation counter and sticky return-error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: clocked state is updated with non-blocking assignments only.
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      starve_q <= '0;
      rd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      if (za_valid && fifo_empty) begin
        rd_err_q <= 1'b1;
      end
    end
  end

  // Outstanding-read tag FIFO: push the owner's id on an accepted read,
  // pop on every returned word.
  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CNT_W'(MAX_PEND));
  assign push       = accept & gnt_rd;
  assign pop        = za_valid & ~fifo_empty;

  // Occupancy follows push/pop; both together leave it unchanged.
  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q <= cnt_d;
    end
  end

  // Tag storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the reset pointers/count make stale entries unreachable.
    if (push) begin
      tag_mem[wr_ptr_q] <= gnt_id;
    end
  end

  assign head_id  = tag_mem[rd_ptr_q];
  assign m0_valid = pop & ~head_id;
  assign m1_valid = pop & head_id;
  assign m0_rdata = za_data;
  assign m1_rdata = za_data;
  assign rd_err   = rd_err_q;
  assign pend_cnt = cnt_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed stimulus with hand-computed
// expectations queued into two scoreboards (issued commands, read returns)
// that independent monitors drain as the DUT presents them.
module tb_sdram_port_arbiter;

  typedef struct {
    bit          port;
    bit          wr;
    logic [21:0] addr;
    logic [15:0] data;
  } cmd_t;

  typedef struct {
    bit          port;
    logic [15:0] data;
  } ret_t;

  logic        clk;
  logic        reset_n;
  logic [21:0] m0_addr, m1_addr, az_addr;
  logic [1:0]  m0_be_n, m1_be_n, az_be_n;
  logic [15:0] m0_data, m1_data, az_data, za_data, m0_rdata, m1_rdata;
  logic        m0_rd_n, m0_wr_n, m1_rd_n, m1_wr_n;
  logic        m0_waitrequest, m1_waitrequest, m0_valid, m1_valid;
  logic        az_rd_n, az_wr_n, za_valid, za_waitrequest, rd_err;
  logic [2:0]  pend_cnt;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   acc_cnt;
  int   lat;
  cmd_t exp_cmd[$];
  ret_t exp_rd[$];

  sdram_port_arbiter dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .m0_addr        (m0_addr),
    .m0_be_n        (m0_be_n),
    .m0_data        (m0_data),
    .m0_rd_n        (m0_rd_n),
    .m0_wr_n        (m0_wr_n),
    .m0_waitrequest (m0_waitrequest),
    .m0_rdata       (m0_rdata),
    .m0_valid       (m0_valid),
    .m1_addr        (m1_addr),
    .m1_be_n        (m1_be_n),
    .m1_data        (m1_data),
    .m1_rd_n        (m1_rd_n),
    .m1_wr_n        (m1_wr_n),
    .m1_waitrequest (m1_waitrequest),
    .m1_rdata       (m1_rdata),
    .m1_valid       (m1_valid),
    .az_addr        (az_addr),
    .az_be_n        (az_be_n),
    .az_data        (az_data),
    .az_rd_n        (az_rd_n),
    .az_wr_n        (az_wr_n),
    .za_data        (za_data),
    .za_valid       (za_valid),
    .za_waitrequest (za_waitrequest),
    .rd_err         (rd_err),
    .pend_cnt       (pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, 32'(act), 32'(exp));
  endtask

  function automatic void push_cmd(input bit port, input bit wr, input logic [21:0] addr,
                                   input logic [15:0] data);
    cmd_t c;
    c.port = port; c.wr = wr; c.addr = addr; c.data = data;
    exp_cmd.push_back(c);
  endfunction

  function automatic void push_rd(input bit port, input logic [15:0] data);
    ret_t r;
    r.port = port; r.data = data;
    exp_rd.push_back(r);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check1({tag, "_m0_wait"}, m0_waitrequest, 1'b1);
    check1({tag, "_m1_wait"}, m1_waitrequest, 1'b1);
    check1({tag, "_m0_valid"}, m0_valid, 1'b0);
    check1({tag, "_m1_valid"}, m1_valid, 1'b0);
    check1({tag, "_az_rd_n"}, az_rd_n, 1'b1);
    check1({tag, "_az_wr_n"}, az_wr_n, 1'b1);
    check1({tag, "_rd_err"}, rd_err, 1'b0);
    check({tag, "_pend"}, 32'(pend_cnt), 32'd0);
    check({tag, "_az_addr"}, 32'(az_addr), 32'd0);
    check({tag, "_az_be_n"}, 32'(az_be_n), 32'd3);
  endtask

  // Wait (bounded) for the port's waitrequest to drop; returns at that negedge.
  task automatic wait_accept(input bit port, output int l);
    l = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if ((port ? m1_waitrequest : m0_waitrequest) == 1'b0) begin
        l = i;
        break;
      end
    end
    if (l == 0) check("accept_timeout", 32'(port ? m1_waitrequest : m0_waitrequest), 32'd0);
  endtask

  // One contention cycle: a controller that returns each read the cycle after accept.
  task automatic contention_step();
    bit fire;
    @(negedge clk);
    if (acc_cnt > 0 && acc_cnt < 18) check("cont_pend", 32'(pend_cnt), 32'd1);
    fire = !az_rd_n && !za_waitrequest;
    @(posedge clk); #1;
    if (fire) acc_cnt++;
    if (acc_cnt == 18) begin
      m0_rd_n = 1'b1;
      m1_rd_n = 1'b1;
    end
    za_valid = fire;
    za_data  = fire ? 16'hD000 + 16'(acc_cnt - 1) : 16'h0;
  endtask

  // Command monitor: every command the controller accepts must be the next expected one.
  initial begin
    cmd_t c;
    forever begin
      @(negedge clk);
      if ((!az_rd_n || !az_wr_n) && !za_waitrequest) begin
        if (exp_cmd.size() == 0) begin
          check("unexpected_cmd", 32'(az_addr), 32'hFFFF_FFFF);
        end else begin
          c = exp_cmd.pop_front();
          check("cmd_port", 32'({m1_waitrequest, m0_waitrequest}), c.port ? 32'd1 : 32'd2);
          check1("cmd_wr", !az_wr_n, c.wr);
          check("cmd_addr", 32'(az_addr), 32'(c.addr));
          if (c.wr) check("cmd_data", 32'(az_data), 32'(c.data));
        end
      end
    end
  end

  // Return monitor: each valid word must go to the expected port with the expected data.
  initial begin
    ret_t r;
    forever begin
      @(negedge clk);
      if (m0_valid || m1_valid) begin
        if (exp_rd.size() == 0) begin
          check("unexpected_valid", 32'({m1_valid, m0_valid}), 32'd0);
        end else begin
          r = exp_rd.pop_front();
          check("rd_port", 32'({m1_valid, m0_valid}), r.port ? 32'd2 : 32'd1);
          check("rd_data", 32'(r.port ? m1_rdata : m0_rdata), 32'(r.data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    m0_addr = '0; m0_be_n = 2'b11; m0_data = '0; m0_rd_n = 1'b1; m0_wr_n = 1'b1;
    m1_addr = '0; m1_be_n = 2'b11; m1_data = '0; m1_rd_n = 1'b1; m1_wr_n = 1'b1;
    za_data = '0; za_valid = 1'b0; za_waitrequest = 1'b0;
    #2;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("idle");

    // Single write on port 0, controller ready.
    @(posedge clk); #1;
    push_cmd(0, 1, 22'h000010, 16'hA5A5);
    m0_addr = 22'h000010; m0_data = 16'hA5A5; m0_be_n = 2'b00; m0_wr_n = 1'b0;
    wait_accept(0, lat);
    check("wr_latency", lat, 2);
    check1("wr_az_wr_n", az_wr_n, 1'b0);
    check("wr_az_be_n", 32'(az_be_n), 32'd0);
    check("wr_pend", 32'(pend_cnt), 32'd0);
    @(posedge clk); #1;
    m0_wr_n = 1'b1; m0_be_n = 2'b11;
    @(negedge clk);
    check1("wr_one_cycle", az_wr_n, 1'b1);

    // Port 1 write stalled two cycles by the controller.
    @(posedge clk); #1;
    za_waitrequest = 1'b1;
    push_cmd(1, 1, 22'h000020, 16'h5A5A);
    m1_addr = 22'h000020; m1_data = 16'h5A5A; m1_be_n = 2'b00; m1_wr_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check1("stall_az_wr_n", az_wr_n, 1'b0);
    check("stall_az_addr", 32'(az_addr), 32'h20);
    check1("stall_m1_wait", m1_waitrequest, 1'b1);
    @(negedge clk);
    check1("stall_m1_wait2", m1_waitrequest, 1'b1);
    @(posedge clk); #1;
    za_waitrequest = 1'b0;
    wait_accept(1, lat);
    check("stall_release_lat", lat, 1);
    @(posedge clk); #1;
    m1_wr_n = 1'b1; m1_be_n = 2'b11;
    repeat (3) @(posedge clk);
    #1;

    // Contention: both read continuously; 8x port 0 then 1x port 1, twice.
    for (int i = 0; i < 18; i++) begin
      push_cmd((i % 9) == 8, 0, ((i % 9) == 8) ? 22'h000200 : 22'h000100, 16'h0);
      push_rd((i % 9) == 8, 16'hD000 + 16'(i));
    end
    m0_addr = 22'h000100; m0_rd_n = 1'b0;
    m1_addr = 22'h000200; m1_rd_n = 1'b0;
    acc_cnt = 0;
    begin
      int iters;
      iters = 0;
      while (acc_cnt < 18 && iters < 200) begin
        contention_step();
        iters++;
      end
      check("cont_accepts", acc_cnt, 18);
      check("cont_cycles", iters, 19);
    end
    contention_step();
    @(negedge clk);
    check("cont_pend_end", 32'(pend_cnt), 32'd0);

    // FIFO full: five port-0 reads, returns withheld.
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) push_cmd(0, 0, 22'h000300 + 22'(i), 16'h0);
    m0_addr = 22'h000300; m0_rd_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_accept(0, lat);
      check("full_lat", lat, (i == 0) ? 2 : 1);
      @(posedge clk); #1;
      m0_addr = 22'h000301 + 22'(i);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check1("full_held_wait", m0_waitrequest, 1'b1);
      check1("full_held_rd_n", az_rd_n, 1'b1);
      check("full_pend", 32'(pend_cnt), 32'd4);
    end
    @(posedge clk); #1;
    push_cmd(0, 0, 22'h000304, 16'h0);
    push_rd(0, 16'h7000);
    za_valid = 1'b1; za_data = 16'h7000;
    @(negedge clk);
    check1("full_pop_wait", m0_waitrequest, 1'b1);
    @(posedge clk); #1;
    za_valid = 1'b0;
    @(negedge clk);
    check1("full_fifth_accept", m0_waitrequest, 1'b0);
    check1("full_fifth_rd_n", az_rd_n, 1'b0);
    check("full_fifth_pend", 32'(pend_cnt), 32'd3);
    @(posedge clk); #1;
    m0_rd_n = 1'b1;
    @(negedge clk);
    check("full_pend_again", 32'(pend_cnt), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      push_rd(0, 16'h7000 + 16'(i));
      @(posedge clk); #1;
      za_valid = 1'b1; za_data = 16'h7000 + 16'(i);
    end
    @(posedge clk); #1;
    za_valid = 1'b0;
    @(negedge clk);
    check("full_drained", 32'(pend_cnt), 32'd0);

    // Push and pop in the same cycle at pend_cnt 2; ordering across ports.
    @(posedge clk); #1;
    push_cmd(0, 0, 22'h000400, 16'h0);
    push_cmd(1, 0, 22'h000401, 16'h0);
    push_cmd(0, 0, 22'h000402, 16'h0);
    push_rd(0, 16'h1111);
    push_rd(1, 16'h2222);
    push_rd(0, 16'h3333);
    m0_addr = 22'h000400; m0_rd_n = 1'b0;
    wait_accept(0, lat);
    @(posedge clk); #1;
    m0_rd_n = 1'b1;
    m1_addr = 22'h000401; m1_rd_n = 1'b0;
    wait_accept(1, lat);
    @(posedge clk); #1;
    m1_rd_n = 1'b1;
    m0_addr = 22'h000402; m0_rd_n = 1'b0;
    @(negedge clk);
    check("pp_pend_before", 32'(pend_cnt), 32'd2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    za_valid = 1'b1; za_data = 16'h1111;
    @(negedge clk);
    check1("pp_accept_with_pop", m0_waitrequest, 1'b0);
    check("pp_pend_during", 32'(pend_cnt), 32'd2);
    @(posedge clk); #1;
    za_valid = 1'b0;
    m0_rd_n = 1'b1;
    @(negedge clk);
    check("pp_pend_after", 32'(pend_cnt), 32'd2);
    @(posedge clk); #1;
    za_valid = 1'b1; za_data = 16'h2222;
    @(posedge clk); #1;
    za_data = 16'h3333;
    @(posedge clk); #1;
    za_valid = 1'b0;
    @(negedge clk);
    check("pp_drained", 32'(pend_cnt), 32'd0);

    // Spurious return with nothing outstanding.
    @(posedge clk); #1;
    za_valid = 1'b1; za_data = 16'hBEEF;
    @(negedge clk);
    check("spur_no_valid", 32'({m1_valid, m0_valid}), 32'd0);
    @(posedge clk); #1;
    za_valid = 1'b0;
    @(negedge clk);
    check1("spur_rd_err", rd_err, 1'b1);
    repeat (3) @(negedge clk);
    check1("spur_rd_err_sticky", rd_err, 1'b1);

    // Reset with three reads outstanding.
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) push_cmd(0, 0, 22'h000500 + 22'(i), 16'h0);
    m0_addr = 22'h000500; m0_rd_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_accept(0, lat);
      @(posedge clk); #1;
      m0_addr = 22'h000501 + 22'(i);
    end
    m0_rd_n = 1'b1;
    @(negedge clk);
    check("rst_pend_before", 32'(pend_cnt), 32'd3);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    za_valid = 1'b1; za_data = 16'hCAFE;
    @(negedge clk);
    check("rst_stale_no_valid", 32'({m1_valid, m0_valid}), 32'd0);
    @(posedge clk); #1;
    za_valid = 1'b0;
    @(negedge clk);
    check1("rst_stale_rd_err", rd_err, 1'b1);
    check("rst_pend_after", 32'(pend_cnt), 32'd0);

    repeat (3) @(negedge clk);
    check("cmd_queue_empty", exp_cmd.size(), 0);
    check("rd_queue_empty", exp_rd.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
